// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one mode-selected ALU (a | b | a+b | a-b) among N requesters,
// with a single registered response port. Optional carry/borrow output: ALU_ARB_CARRY_EN.
module alu_share_arbiter #(
  parameter int N   = 4,
  parameter int W   = 10,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  input  logic [2*N-1:0]   req_mode,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic             rsp_is_zero
`ifdef ALU_ARB_CARRY_EN
  ,
  output logic             rsp_carry
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   y_q, y_d;
  logic           z_q, z_d;
`ifdef ALU_ARB_CARRY_EN
  logic           c_q, c_d;
  logic           alu_c;
  logic [W:0]     sum, diff;
`else
  logic [W-1:0]   sum, diff;
`endif

  logic           open_win;
  logic           found;
  logic           hs;
  logic [N-1:0]   gnt_oh;
  logic [IDW-1:0] gnt_idx;
  int unsigned    idx;
  logic [W-1:0]   a_sel, b_sel, alu_y;
  logic [1:0]     m_sel;

  // Rotating priority search starting at ptr_q; first valid requester wins.
  always_comb begin
    open_win = (state_q == IDLE) || rsp_ready;
    found    = 1'b0;
    gnt_oh   = '0;
    gnt_idx  = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IDW'(idx);
      end
    end
    hs        = found && open_win && !reset;
    req_ready = hs ? gnt_oh : '0;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    m_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_oh[i]) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
        m_sel = req_mode[2*i +: 2];
      end
    end
`ifdef ALU_ARB_CARRY_EN
    // Extra MSB carries the carry-out of a+b and the borrow (a < b) of a-b.
    sum   = {1'b0, a_sel} + {1'b0, b_sel};
    diff  = {1'b0, a_sel} - {1'b0, b_sel};
    alu_c = 1'b0;
`else
    sum   = a_sel + b_sel;
    diff  = a_sel - b_sel;
`endif
    alu_y = a_sel;
    unique case (m_sel)
      2'b00: alu_y = a_sel;
      2'b01: alu_y = b_sel;
      2'b10: begin
        alu_y = sum[W-1:0];
`ifdef ALU_ARB_CARRY_EN
        alu_c = sum[W];
`endif
      end
      default: begin
        alu_y = diff[W-1:0];
`ifdef ALU_ARB_CARRY_EN
        alu_c = diff[W];
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    y_d     = y_q;
    z_d     = z_q;
`ifdef ALU_ARB_CARRY_EN
    c_d     = c_q;
`endif
    if (hs) begin
      state_d = HOLD;
      ptr_d   = IDW'((32'(gnt_idx) + 1) % N);
      id_d    = gnt_idx;
      y_d     = alu_y;
      z_d     = (alu_y == '0);
`ifdef ALU_ARB_CARRY_EN
      c_d     = alu_c;
`endif
    end else if (state_q == HOLD && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      y_q     <= '0;
      z_q     <= 1'b1;
`ifdef ALU_ARB_CARRY_EN
      c_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      y_q     <= y_d;
      z_q     <= z_d;
`ifdef ALU_ARB_CARRY_EN
      c_q     <= c_d;
`endif
    end
  end

  assign rsp_valid   = (state_q == HOLD);
  assign rsp_id      = id_q;
  assign rsp_y       = y_q;
  assign rsp_is_zero = z_q;
`ifdef ALU_ARB_CARRY_EN
  assign rsp_carry   = c_q;
`endif

endmodule
